// File: rtl/mod3_ones_tx_if.sv
// Handshake and serial-line bundle for the ones-count-mod-3 transmitter.
`timescale 1ns/1ps
interface mod3_ones_tx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_en;
  logic              tx_last;
  logic              busy;

  // Producer side: offers words, watches the serial line.
  modport master (
    output in_data, in_valid,
    input  in_ready, tx_bit, tx_en, tx_last, busy
  );

  // Transmitter side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, tx_bit, tx_en, tx_last, busy
  );
endinterface

// File: rtl/mod3_ones_tx.sv
// Serial transmitter that shifts out a payload word and appends two pad bits
// so that every frame carries a multiple of three ones.
`timescale 1ns/1ps
module mod3_ones_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  mod3_ones_tx_if.slave bus
);
  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PAD1, PAD2} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [1:0]        resid, resid_next;
  logic              head;
  logic              ready;
  logic              accept;

  // Bit currently presented on the line while shifting payload.
  assign head = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

  // State, shift register, bit counter and running ones-residue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      resid   <= '0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      resid   <= resid_next;
    end
  end

  // Next-state logic and output decode; outputs depend on registers only.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    resid_next   = resid;
    ready        = 1'b0;
    bus.tx_bit   = 1'b0;
    bus.tx_en    = 1'b0;
    bus.tx_last  = 1'b0;
    bus.busy     = 1'b0;

    ready  = (state == IDLE) || (state == PAD2);
    accept = bus.in_valid & ready;

    case (state)
      IDLE: ;
      SHIFT: begin
        bus.tx_bit   = head;
        bus.tx_en    = 1'b1;
        shreg_next   = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0}
                                 : {1'b0, shreg[DATA_W-1:1]};
        bit_cnt_next = bit_cnt + CNT_W'(1);
        if (head) resid_next = (resid == 2'd2) ? 2'd0 : resid + 2'd1;
        if (bit_cnt == CNT_W'(DATA_W - 1)) state_next = PAD1;
      end
      PAD1: begin
        // Pad need (3-resid) mod 3 is at least one whenever resid is nonzero.
        bus.tx_bit = (resid != 2'd0);
        bus.tx_en  = 1'b1;
        state_next = PAD2;
      end
      PAD2: begin
        // Need of two arises only for resid == 1.
        bus.tx_bit  = (resid == 2'd1);
        bus.tx_en   = 1'b1;
        bus.tx_last = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Acceptance reloads everything, so no residue carries across frames.
    if (accept) begin
      state_next   = SHIFT;
      shreg_next   = bus.in_data;
      bit_cnt_next = '0;
      resid_next   = '0;
    end

    bus.busy     = bus.tx_en;
    bus.in_ready = ready;
  end
endmodule

// File: tb/tb_mod3_ones_tx.sv
// Randomized self-checking bench: two transmitters (MSB-first and LSB-first)
// fed the same traffic and compared cycle by cycle against a frame-queue model.
`timescale 1ns/1ps
module tb_mod3_ones_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod3_ones_tx_if #(.DATA_W(8)) bm ();
  mod3_ones_tx_if #(.DATA_W(8)) bl ();

  mod3_ones_tx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bm));
  mod3_ones_tx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bl));

  typedef struct packed { logic b; logic last; } ent_t;

  ent_t       exp_m[$];
  ent_t       exp_l[$];
  logic [7:0] words_q[$];
  logic [9:0] last_m, last_l;
  int         max_run;

  task automatic drive(input logic v, input logic [7:0] d);
    bm.in_valid = v; bm.in_data = d;
    bl.in_valid = v; bl.in_data = d;
  endtask

  // Model: a frame is the payload bits in line order followed by the pad pair
  // that brings its ones count to a multiple of three. Ready when at most the
  // final bit of the current frame remains.
  task automatic run_traffic(input int valid_pct, input int budget, input string name);
    int         cyc = 0;
    int         ones_m = 0, ones_l = 0, len_m = 0, run_m = 0;
    logic [9:0] cap_m = '0, cap_l = '0;
    logic [4:0] obs, want;
    logic       acc;
    int         p;
    max_run = 0;
    while ((words_q.size() > 0 || exp_m.size() > 0) && cyc < budget) begin
      want = (exp_m.size() > 0) ? {1'b1, exp_m[0].b, exp_m[0].last, 1'b1, exp_m.size() <= 1}
                                : 5'b00001;
      obs  = {bm.tx_en, bm.tx_bit, bm.tx_last, bm.busy, bm.in_ready};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL %s msb cyc=%0d {en,bit,last,busy,rdy} got %b want %b", name, cyc, obs, want);
      end
      want = (exp_l.size() > 0) ? {1'b1, exp_l[0].b, exp_l[0].last, 1'b1, exp_l.size() <= 1}
                                : 5'b00001;
      obs  = {bl.tx_en, bl.tx_bit, bl.tx_last, bl.busy, bl.in_ready};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL %s lsb cyc=%0d {en,bit,last,busy,rdy} got %b want %b", name, cyc, obs, want);
      end

      // Observed-frame scoreboard, independent of the model queues.
      run_m = bm.tx_en ? run_m + 1 : 0;
      if (run_m > max_run) max_run = run_m;
      if (bm.tx_en) begin
        len_m++;
        cap_m = {cap_m[8:0], bm.tx_bit};
        if (bm.tx_bit) ones_m++;
        if (bm.tx_last) begin
          checks++;
          if ((ones_m % 3) != 0 || len_m != 10) begin
            errors++;
            $display("FAIL %s msb_frame ones=%0d len=%0d want ones%%3=0 len=10", name, ones_m, len_m);
          end
          last_m = cap_m; ones_m = 0; len_m = 0;
        end
      end
      if (bl.tx_en) begin
        cap_l = {cap_l[8:0], bl.tx_bit};
        if (bl.tx_bit) ones_l++;
        if (bl.tx_last) begin
          checks++;
          if ((ones_l % 3) != 0) begin
            errors++;
            $display("FAIL %s lsb_frame ones=%0d want ones%%3=0", name, ones_l);
          end
          last_l = cap_l; ones_l = 0;
        end
      end

      if (words_q.size() > 0 && $urandom_range(99) < valid_pct) drive(1'b1, words_q[0]);
      else drive(1'b0, 8'($urandom));

      acc = bm.in_valid && (exp_m.size() <= 1);
      if (exp_m.size() > 0) begin
        void'(exp_m.pop_front());
        void'(exp_l.pop_front());
      end
      if (acc) begin
        p = (3 - ($countones(words_q[0]) % 3)) % 3;
        for (int i = 0; i < 8; i++) begin
          exp_m.push_back('{b: words_q[0][7-i], last: 1'b0});
          exp_l.push_back('{b: words_q[0][i],   last: 1'b0});
        end
        exp_m.push_back('{b: (p >= 1), last: 1'b0});
        exp_l.push_back('{b: (p >= 1), last: 1'b0});
        exp_m.push_back('{b: (p == 2), last: 1'b1});
        exp_l.push_back('{b: (p == 2), last: 1'b1});
        void'(words_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    drive(1'b0, '0);
    checks++;
    if (cyc >= budget) begin
      errors++;
      $display("FAIL %s timeout after %0d cycles, words left %0d", name, cyc, words_q.size());
      words_q.delete(); exp_m.delete(); exp_l.delete();
    end else if (bm.tx_en !== 1'b0 || bl.tx_en !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after tx_en got %b%b want 00", name, bm.tx_en, bl.tx_en);
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    drive(1'b0, '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    obs = {bm.tx_en, bm.tx_bit, bm.tx_last, bm.busy, bm.in_ready,
           bl.tx_en, bl.tx_bit, bl.tx_last, bl.busy, bl.in_ready};
    checks++;
    if (obs !== 10'b00001_00001) begin
      errors++;
      $display("FAIL reset_during outputs got %b want 0000100001", obs);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    obs = {bm.tx_en, bm.tx_bit, bm.tx_last, bm.busy, bm.in_ready,
           bl.tx_en, bl.tx_bit, bl.tx_last, bl.busy, bl.in_ready};
    checks++;
    if (obs !== 10'b00001_00001) begin
      errors++;
      $display("FAIL reset_after outputs got %b want 0000100001", obs);
    end
  endtask

  task automatic test_directed();
    logic [7:0] w  [5] = '{8'hB5, 8'h00, 8'h01, 8'hFF, 8'h07};
    logic [9:0] fm [5] = '{10'b1011010110, 10'b0000000000, 10'b0000000111,
                           10'b1111111110, 10'b0000011100};
    logic [9:0] fl [5] = '{10'b1010110110, 10'b0000000000, 10'b1000000011,
                           10'b1111111110, 10'b1110000000};
    for (int i = 0; i < 5; i++) begin
      words_q.push_back(w[i]);
      last_m = 'x; last_l = 'x;
      run_traffic(100, 40, "directed");
      checks++;
      if (last_m !== fm[i] || last_l !== fl[i]) begin
        errors++;
        $display("FAIL directed_frame word=%h msb got %b want %b, lsb got %b want %b",
                 w[i], last_m, fm[i], last_l, fl[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    words_q.push_back(8'hB5);
    words_q.push_back(8'h0F);
    run_traffic(100, 60, "b2b");
    checks++;
    if (max_run != 20 || last_m !== 10'b0000111111) begin
      errors++;
      $display("FAIL b2b run=%0d want 20, last frame %b want 0000111111", max_run, last_m);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) words_q.push_back(8'($urandom));
    run_traffic(100, 2000, "rand_full");
    for (int i = 0; i < 60; i++) words_q.push_back(8'($urandom));
    run_traffic(35, 5000, "rand_gaps");
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    drive(1'b1, 8'hB5);
    @(negedge clk);
    drive(1'b0, 8'h5A);
    repeat (3) @(negedge clk);   // payload bit 4 on the line now
    #2 reset = 1'b1;
    #1;
    obs = {bm.tx_en, bm.tx_bit, bm.tx_last, bm.busy, bm.in_ready,
           bl.tx_en, bl.tx_bit, bl.tx_last, bl.busy, bl.in_ready};
    checks++;
    if (obs !== 10'b00001_00001) begin
      errors++;
      $display("FAIL reset_mid_abort outputs got %b want 0000100001", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_m.delete(); exp_l.delete(); words_q.delete();
    words_q.push_back(8'hB5);
    last_m = 'x; last_l = 'x;
    run_traffic(100, 40, "reset_mid");
    checks++;
    if (last_m !== 10'b1011010110 || last_l !== 10'b1010110110) begin
      errors++;
      $display("FAIL reset_mid_frame msb got %b want 1011010110, lsb got %b want 1010110110",
               last_m, last_l);
    end
  endtask

  initial begin
    drive(1'b0, '0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
